// File: rtl/ysyx_22040931_ifu.sv
// Instruction fetch unit with a single outstanding request and an IF/ID register.
// Optional feature: YSYX_22040931_IFU_MISALIGN_EN keeps misaligned redirect targets and flags them.
module ysyx_22040931_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        mux_pc,
    input  logic [63:0] branch,
    output logic        inst_req_valid,
    input  logic        inst_req_ready,
    output logic [63:0] inst_req_addr,
    input  logic        inst_rsp_valid,
    input  logic [31:0] inst_rsp_data,
    output logic [63:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o,
    output logic        fetch_misalign
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_fetch_pc;
    logic [63:0] r_req_pc;
    logic [31:0] r_buf_data;
    logic [63:0] r_pc;
    logic [31:0] r_instr;
    logic        r_valid;
    logic        r_fetch_misalign;

    logic        w_redirect;
    logic [63:0] w_target;
    logic        w_target_mis;
    logic        w_suppress;
    logic        w_req_valid;
    logic        w_fire;
    logic        w_load_rsp;
    logic        w_load_buf;
    logic        w_capture;

    // A stalled decode stage cannot accept a redirect.
    assign w_redirect = mux_pc & ~stall;

`ifdef YSYX_22040931_IFU_MISALIGN_EN
    assign w_target     = branch;
    assign w_target_mis = |branch[1:0];
    assign w_suppress   = r_fetch_misalign;
`else
    assign w_target     = branch & ~64'h0000_0000_0000_0003;
    assign w_target_mis = 1'b0;
    assign w_suppress   = 1'b0;
`endif

    assign w_fire         = w_req_valid & inst_req_ready;
    assign inst_req_valid = w_req_valid;
    assign inst_req_addr  = r_fetch_pc;
    assign pc_o           = r_pc;
    assign instr_o        = r_instr;
    assign valid_o        = r_valid;
    assign fetch_misalign = r_fetch_misalign;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_valid = 1'b0;
        w_load_rsp  = 1'b0;
        w_load_buf  = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_valid = ~w_redirect & ~w_suppress & ~reset;
                if (!w_redirect && w_req_valid && inst_req_ready) begin
                    w_state_nxt = WAIT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                // A response arriving with the redirect is consumed here, so nothing is left to drop.
                if (w_redirect) begin
                    w_state_nxt = inst_rsp_valid ? IDLE : DROP;
                end else if (inst_rsp_valid) begin
                    if (stall) begin
                        w_capture   = 1'b1;
                        w_state_nxt = HOLD;
                    end else begin
                        w_load_rsp  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            HOLD: begin
                if (w_redirect) begin
                    w_state_nxt = IDLE;
                end else if (!stall) begin
                    w_load_buf  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            DROP: begin
                if (inst_rsp_valid) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DROP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fetch_pc       <= RESET_PC;
            r_req_pc         <= 64'h0000_0000_0000_0000;
            r_buf_data       <= 32'h0000_0000;
            r_pc             <= 64'h0000_0000_0000_0000;
            r_instr          <= NOP;
            r_valid          <= 1'b0;
            r_fetch_misalign <= 1'b0;
        end else begin
            if (w_redirect) begin
                r_fetch_pc       <= w_target;
                r_fetch_misalign <= w_target_mis;
            end else if (w_fire) begin
                r_fetch_pc <= r_fetch_pc + 64'd4;
            end
            if (w_fire) begin
                r_req_pc <= r_fetch_pc;
            end
            if (w_capture) begin
                r_buf_data <= inst_rsp_data;
            end
            // Every non-stalled edge either presents a new entry or a bubble.
            if (!stall) begin
                if (w_load_rsp) begin
                    r_pc    <= r_req_pc;
                    r_instr <= inst_rsp_data;
                    r_valid <= 1'b1;
                end else if (w_load_buf) begin
                    r_pc    <= r_req_pc;
                    r_instr <= r_buf_data;
                    r_valid <= 1'b1;
                end else begin
                    r_instr <= NOP;
                    r_valid <= 1'b0;
                end
            end
        end
    end

endmodule
